// File: rtl/core_pkg.sv
// Shared decode definitions for the RV32I/RV64I core pipeline.
package core_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator; shared with the compressed-instruction expander.
module imm_gen
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Widen to XLEN with the sign of the 32-bit immediate.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage_pipe.sv
// Registered instruction-decode stage: field split, immediate, format, illegal flag,
// with valid/ready handshake, backpressure and flush.
module id_stage_pipe
  import core_pkg::*;
#(
  parameter int XLEN          = XLEN_DEFAULT,
  parameter bit CHECK_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic            out_rd_we,
  output logic            out_illegal
);

  logic [6:0]      opcode;
  logic [4:0]      rd;
  fmt_e            cls_fmt;
  fmt_e            dec_fmt;
  logic            cls_rs1, cls_rs2, cls_we, cls_known;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;
  logic            accept;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];

  always_comb begin
    cls_fmt   = FMT_R;
    cls_rs1   = 1'b0;
    cls_rs2   = 1'b0;
    cls_we    = 1'b0;
    cls_known = 1'b1;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        cls_fmt = FMT_U;
        cls_we  = 1'b1;
      end
      OPC_JAL: begin
        cls_fmt = FMT_J;
        cls_we  = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: begin
        cls_fmt = FMT_I;
        cls_rs1 = 1'b1;
        cls_we  = 1'b1;
      end
      OPC_BRANCH: begin
        cls_fmt = FMT_B;
        cls_rs1 = 1'b1;
        cls_rs2 = 1'b1;
      end
      OPC_STORE: begin
        cls_fmt = FMT_S;
        cls_rs1 = 1'b1;
        cls_rs2 = 1'b1;
      end
      OPC_OP: begin
        cls_fmt = FMT_R;
        cls_rs1 = 1'b1;
        cls_rs2 = 1'b1;
        cls_we  = 1'b1;
      end
      default: cls_known = 1'b0;
    endcase
  end

  assign dec_illegal = CHECK_ILLEGAL && (!cls_known || (in_instr[1:0] != 2'b11));
  // Illegal encodings collapse to R format so the immediate comes out as zero.
  assign dec_fmt     = dec_illegal ? FMT_R : cls_fmt;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  assign in_ready = (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_opcode   <= '0;
      out_rd       <= '0;
      out_funct3   <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_funct7   <= '0;
      out_imm      <= '0;
      out_fmt      <= '0;
      out_rs1_used <= 1'b0;
      out_rs2_used <= 1'b0;
      out_rd_we    <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_opcode   <= opcode;
      out_rd       <= rd;
      out_funct3   <= in_instr[14:12];
      out_rs1      <= in_instr[19:15];
      out_rs2      <= in_instr[24:20];
      out_funct7   <= in_instr[31:25];
      out_imm      <= dec_imm;
      out_fmt      <= dec_fmt;
      out_rs1_used <= cls_rs1 && !dec_illegal;
      out_rs2_used <= cls_rs2 && !dec_illegal;
      out_rd_we    <= cls_we && !dec_illegal && (rd != 5'd0);
      out_illegal  <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
